pbc_div_scheduler: RTL
======================

# pbc_div_scheduler

Sequencing controller that computes the six Pbc ratios (margin / n) on a single shared, pipelined divider, replacing six parallel dividers. It accepts one margin table plus the two row totals, issues the six divisions in order with tags, collects the tagged (possibly out-of-order) results, and presents all six packed quotients with a valid/ready handshake. Zero divisors are detected and skipped without using the divider. It sits between the contingency-table counter stage and the Boost interaction-statistic stage.

## Interface
- DATA_WIDTH, 16, width of margin entries and n values
- RESULT_WIDTH, 32, width of one quotient
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  margin_table_in/n_in valid
- in_ready  out  1  block can capture a new table (high only in IDLE)
- margin_table_in  in  6*DATA_WIDTH  six dividends; entry k at [k*DATA_WIDTH +: DATA_WIDTH]
- n_in  in  2*DATA_WIDTH  divisors; n0 for k=0..2, n1 for k=3..5
- div_req_valid  out  1  request to shared divider
- div_req_ready  in  1  divider accepts request
- div_dividend  out  DATA_WIDTH  dividend of current request
- div_divisor  out  DATA_WIDTH  divisor of current request
- div_req_tag  out  3  index k of current request
- div_resp_valid  in  1  divider result valid (no backpressure)
- div_resp_tag  in  3  index of returned result
- div_resp_data  in  RESULT_WIDTH  quotient
- Pbc_out  out  6*RESULT_WIDTH  packed results, entry k at [k*RESULT_WIDTH +: RESULT_WIDTH]
- out_valid  out  1  Pbc_out complete and stable
- out_ready  in  1  consumer accepts Pbc_out
- div0_flags  out  6  bit k set when divisor for k was zero
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset -> IDLE.
- IDLE: in_ready=1. On in_valid: latch inputs, clear done mask, Pbc_out, div0_flags; issue index idx=0; go ISSUE.
- ISSUE, per idx: divisor = n0 if idx<3 else n1.
  - Divisor zero: no request; result k forced to 0, div0_flags[idx] and done[idx] set; idx++ this cycle.
  - Else div_req_valid=1 with dividend/divisor/tag=idx; idx++ only on div_req_ready. Outputs stable while stalled.
  - After idx=5 handled -> WAIT.
- Responses accepted in ISSUE, WAIT: on div_resp_valid with tag<6 and done[tag]=0, write Pbc_out[tag], set done[tag]. Tag>=6, duplicate tag, or response in IDLE/DONE: ignored, no state change.
- WAIT: when (done | incoming response bit) == 6'h3F -> DONE at that edge.
- DONE: out_valid=1; Pbc_out, div0_flags held. On out_ready -> IDLE.
- ISSUE skip and response write for different k in the same cycle both take effect.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values; later stale divider responses ignored (IDLE).

## Timing
- Reset values: state IDLE, in_ready=1, div_req_valid=0, div_dividend/div_divisor/div_req_tag=0, Pbc_out=0, out_valid=0, div0_flags=0, busy=0.
- Input handshake at edge E: first request valid in cycle after E.
- No stalls, no zero divisors, divider latency L>=1 (accepted at edge t, response cycle t+L-1, captured at edge t+L-1... response valid in cycle after t+L-1): requests accepted edges E+1..E+6; out_valid asserted the cycle after the edge capturing tag 5's response, i.e. E+6+L.
- All divisors zero: 6 skip cycles, out_valid the cycle after edge E+7 (ISSUE->WAIT->DONE).
- Back-to-back: with out_ready held high, in_ready returns one cycle after out_valid; throughput one table per 8+L cycles minimum.
- in_valid ignored outside IDLE; inputs need only be valid at capture edge.

## Test plan
- margin={10,20,30,40,50,60}, n={10,20}, divider L=3, req_ready=1 -> six requests tags 0..5 consecutive; Pbc_out={1,2,3,2,2,3}; out_valid at E+9; div0_flags=0.
- Divider returns tags order 5,3,1,0,2,4 -> same Pbc_out; out_valid one cycle after last response.
- n={0,7}, margin k3..5={14,21,28} -> only tags 3..5 issued; Pbc_out[0..2]=0, [3..5]={2,3,4}; div0_flags=6'b000111.
- div_req_ready toggling 1,0,0,1... -> request fields stable during stalls, each tag issued exactly once; duplicate tag-2 response ignored.
- out_ready held low 10 cycles in DONE -> out_valid/Pbc_out stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
- rst low during WAIT -> all outputs reset asynchronously; late div_resp_valid after release leaves Pbc_out=0, state IDLE.

Source files
------------

// File: rtl/pbc_div_scheduler.sv
// Schedules the six Pbc ratios (margin / n) onto one shared pipelined divider,
// collects tagged out-of-order quotients and presents them as one packed result.
module pbc_div_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6*DATA_WIDTH-1:0]     margin_table_in,
  input  logic [2*DATA_WIDTH-1:0]     n_in,
  output logic                        div_req_valid,
  input  logic                        div_req_ready,
  output logic [DATA_WIDTH-1:0]       div_dividend,
  output logic [DATA_WIDTH-1:0]       div_divisor,
  output logic [2:0]                  div_req_tag,
  input  logic                        div_resp_valid,
  input  logic [2:0]                  div_resp_tag,
  input  logic [RESULT_WIDTH-1:0]     div_resp_data,
  output logic [6*RESULT_WIDTH-1:0]   Pbc_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [5:0]                  div0_flags,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [6*DATA_WIDTH-1:0]     margin_q, margin_d;
  logic [2*DATA_WIDTH-1:0]     n_q, n_d;
  logic [6*RESULT_WIDTH-1:0]   pbc_q, pbc_d;
  logic [5:0]                  done_q, done_d;
  logic [5:0]                  div0_q, div0_d;

  logic [5:0]                  resp_hit;
  logic [DATA_WIDTH-1:0]       cur_dividend;
  logic [DATA_WIDTH-1:0]       cur_divisor;
  logic                        advance;

  // A response only counts while a table is in flight, for a valid tag not yet filled.
  always_comb begin
    resp_hit = '0;
    for (int k = 0; k < 6; k++) begin
      if (div_resp_valid && (state_q == ISSUE || state_q == WAIT) &&
          div_resp_tag == 3'(k) && !done_q[k]) begin
        resp_hit[k] = 1'b1;
      end
    end
  end

  always_comb begin
    cur_dividend = '0;
    for (int k = 0; k < 6; k++) begin
      if (idx_q == 3'(k)) cur_dividend = margin_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
    cur_divisor = (idx_q < 3'd3) ? n_q[DATA_WIDTH-1:0] : n_q[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    margin_d      = margin_q;
    n_d           = n_q;
    pbc_d         = pbc_q;
    done_d        = done_q;
    div0_d        = div0_q;
    div_req_valid = 1'b0;
    advance       = 1'b0;

    for (int k = 0; k < 6; k++) begin
      if (resp_hit[k]) begin
        pbc_d[k*RESULT_WIDTH +: RESULT_WIDTH] = div_resp_data;
        done_d[k] = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          margin_d = margin_table_in;
          n_d      = n_in;
          pbc_d    = '0;
          done_d   = '0;
          div0_d   = '0;
          idx_d    = 3'd0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // Zero divisor: result stays 0 and the divider is never used for this index.
        if (cur_divisor == '0) begin
          for (int k = 0; k < 6; k++) begin
            if (idx_q == 3'(k)) begin
              div0_d[k] = 1'b1;
              done_d[k] = 1'b1;
              pbc_d[k*RESULT_WIDTH +: RESULT_WIDTH] = '0;
            end
          end
          advance = 1'b1;
        end else begin
          div_req_valid = 1'b1;
          advance       = div_req_ready;
        end
        if (advance) begin
          if (idx_q == 3'd5) state_d = WAIT;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      WAIT: begin
        if ((done_q | resp_hit) == 6'h3F) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      margin_q <= '0;
      n_q      <= '0;
      pbc_q    <= '0;
      done_q   <= '0;
      div0_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      margin_q <= margin_d;
      n_q      <= n_d;
      pbc_q    <= pbc_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign div_dividend = div_req_valid ? cur_dividend : '0;
  assign div_divisor  = div_req_valid ? cur_divisor  : '0;
  assign div_req_tag  = div_req_valid ? idx_q        : 3'd0;
  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == DONE);
  assign Pbc_out      = pbc_q;
  assign div0_flags   = div0_q;

endmodule
